// File: rtl/shared_bus_if.sv
// Shared memory bus controller interface: arbitor grants, per-master command
// and write data, per-master completion strobes, and the shared bus itself.
interface shared_bus_if #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int LW = 4
);
    logic          grant1;
    logic          grant2;
    logic [AW-1:0] m1_addr;
    logic          m1_we;
    logic [LW-1:0] m1_len;
    logic [DW-1:0] m1_wdata;
    logic [AW-1:0] m2_addr;
    logic          m2_we;
    logic [LW-1:0] m2_len;
    logic [DW-1:0] m2_wdata;
    logic          m1_ack;
    logic          m2_ack;
    logic          m1_done;
    logic          m2_done;
    logic          abort;
    logic [DW-1:0] rdata;
    logic          bus_en;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;

    // Controller side.
    modport slave (
        input  grant1, grant2,
        input  m1_addr, m1_we, m1_len, m1_wdata,
        input  m2_addr, m2_we, m2_len, m2_wdata,
        input  bus_rdata,
        output m1_ack, m2_ack, m1_done, m2_done, abort, rdata,
        output bus_en, bus_we, bus_addr, bus_wdata
    );

    // Masters, arbitor and memory side.
    modport master (
        output grant1, grant2,
        output m1_addr, m1_we, m1_len, m1_wdata,
        output m2_addr, m2_we, m2_len, m2_wdata,
        output bus_rdata,
        input  m1_ack, m2_ack, m1_done, m2_done, abort, rdata,
        input  bus_en, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/shared_bus_ctrl.sv
// Shared bus controller: runs the granted master's burst of len+1 beats on the
// shared memory bus, each beat holding bus_en for WAIT_STATES+1 cycles, and
// returns per-beat ack/rdata, a done pulse on the last beat, or abort when the
// owner's grant disappears mid-burst. All outputs are registered.
module shared_bus_ctrl #(
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int LW          = 4,
    parameter int WAIT_STATES = 2
) (
    input logic          clk,
    input logic          rst,
    shared_bus_if.slave  bif
);
    localparam int WSW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WSW-1:0] WS_LOAD = WSW'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;          // 0: master 1, 1: master 2
    logic [LW-1:0] beat_q, beat_d;            // beats remaining after the current one
    logic [WSW-1:0] ws_q, ws_d;               // cycles left in the current beat
    logic          bus_en_q, bus_en_d;
    logic          bus_we_q, bus_we_d;        // also serves as the latched command direction
    logic [AW-1:0] bus_addr_q, bus_addr_d;    // also serves as the running burst address
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ack1_q, ack1_d, ack2_q, ack2_d;
    logic          done1_q, done1_d, done2_q, done2_d;
    logic          abort_q, abort_d;

    logic          owner_grant;
    logic [DW-1:0] owner_wdata;

    assign owner_grant = owner_q ? bif.grant2   : bif.grant1;
    assign owner_wdata = owner_q ? bif.m2_wdata : bif.m1_wdata;

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        owner_d     = owner_q;
        beat_d      = beat_q;
        ws_d        = ws_q;
        bus_en_d    = bus_en_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        ack1_d      = 1'b0;
        ack2_d      = 1'b0;
        done1_d     = 1'b0;
        done2_d     = 1'b0;
        abort_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bif.grant1 || bif.grant2) begin
                    // grant1 wins a tie.
                    owner_d     = !bif.grant1;
                    bus_addr_d  = bif.grant1 ? bif.m1_addr  : bif.m2_addr;
                    bus_we_d    = bif.grant1 ? bif.m1_we    : bif.m2_we;
                    beat_d      = bif.grant1 ? bif.m1_len   : bif.m2_len;
                    bus_wdata_d = bif.grant1 ? bif.m1_wdata : bif.m2_wdata;
                    ws_d        = WS_LOAD;
                    bus_en_d    = 1'b1;
                    state_d     = ACCESS;
                end
            end

            ACCESS: begin
                if (!owner_grant) begin
                    // Grant lost: drop the bus now, no ack or done for the cut beat.
                    abort_d  = 1'b1;
                    bus_en_d = 1'b0;
                    bus_we_d = 1'b0;
                    state_d  = IDLE;
                end else if (ws_q == '0) begin
                    rdata_d    = bus_we_q ? '0 : bif.bus_rdata;
                    ack1_d     = !owner_q;
                    ack2_d     = owner_q;
                    bus_addr_d = bus_addr_q + AW'(1);
                    if (beat_q != '0) begin
                        // Next beat follows with no gap in bus_en.
                        beat_d      = beat_q - LW'(1);
                        ws_d        = WS_LOAD;
                        bus_wdata_d = owner_wdata;
                    end else begin
                        done1_d  = !owner_q;
                        done2_d  = owner_q;
                        bus_en_d = 1'b0;
                        bus_we_d = 1'b0;
                        state_d  = RELEASE;
                    end
                end else begin
                    ws_d = ws_q - WSW'(1);
                end
            end

            RELEASE: begin
                // A grant still held after done is never restarted.
                if (!owner_grant) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            beat_q      <= '0;
            ws_q        <= '0;
            bus_en_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            ack1_q      <= 1'b0;
            ack2_q      <= 1'b0;
            done1_q     <= 1'b0;
            done2_q     <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            owner_q     <= owner_d;
            beat_q      <= beat_d;
            ws_q        <= ws_d;
            bus_en_q    <= bus_en_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            ack1_q      <= ack1_d;
            ack2_q      <= ack2_d;
            done1_q     <= done1_d;
            done2_q     <= done2_d;
            abort_q     <= abort_d;
        end
    end

    assign bif.bus_en    = bus_en_q;
    assign bif.bus_we    = bus_we_q;
    assign bif.bus_addr  = bus_addr_q;
    assign bif.bus_wdata = bus_wdata_q;
    assign bif.rdata     = rdata_q;
    assign bif.m1_ack    = ack1_q;
    assign bif.m2_ack    = ack2_q;
    assign bif.m1_done   = done1_q;
    assign bif.m2_done   = done2_q;
    assign bif.abort     = abort_q;
endmodule
